// File: rtl/serializer_tx_scheduler_pkg.sv
// rtl/serializer_tx_scheduler_pkg.sv - shared types and width helpers for the serializer tx scheduler
package serializer_tx_scheduler_pkg;

    // IDLE arbitrates, SEND carries the load strobe, WAIT covers the serializer shift time
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_t;

    localparam int DEF_N_REQ      = 2;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FRAME_CLKS = 12;

    // Index width for a count of n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_tx_scheduler_rr_arbiter.sv
// rtl/serializer_tx_scheduler_rr_arbiter.sv - combinational round-robin arbiter searching upward from ptr
module serializer_tx_scheduler_rr_arbiter
    import serializer_tx_scheduler_pkg::*;
#(
    parameter int N  = DEF_N_REQ,
    parameter int GW = idx_width(N)
)(
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [GW-1:0] gnt_idx,
    output logic          any
);

    // First requester at or above ptr wins, wrapping past N-1 back to 0
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt_idx  = GW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serializer_tx_scheduler.sv
// rtl/serializer_tx_scheduler.sv - round-robin sharing of one byte serializer among N_REQ producers
module serializer_tx_scheduler
    import serializer_tx_scheduler_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_CLKS = DEF_FRAME_CLKS
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [DATA_W-1:0]            ser_data,
    output logic                         ser_send,
    output logic [idx_width(N_REQ)-1:0]  grant_id,
    output logic                         busy
);

    localparam int GW = idx_width(N_REQ);
    localparam int CW = idx_width(FRAME_CLKS);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(FRAME_CLKS - 3);
    localparam logic [GW-1:0] LAST_IDX  = GW'(N_REQ - 1);

    sched_state_t        state;
    logic [GW-1:0]       rr_ptr;
    logic [CW-1:0]       wait_cnt;

    logic [N_REQ-1:0]    arb_gnt;
    logic [GW-1:0]       arb_idx;
    logic                arb_any;
    logic                accept;
    logic [DATA_W-1:0]   sel_data;

    serializer_tx_scheduler_rr_arbiter #(
        .N  (N_REQ),
        .GW (GW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // A byte is taken only from IDLE with the scheduler enabled and not in reset
    always_comb begin
        accept    = (state == ST_IDLE) && en && arb_any && !rst;
        req_ready = accept ? arb_gnt : '0;
    end

    // Byte lane of the granted requester
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == GW'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Frame FSM: registered strobe, busy flag, held byte/grant and the frame-gap counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            ser_data <= '0;
            ser_send <= 1'b0;
            grant_id <= '0;
            busy     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ser_data <= sel_data;
                        grant_id <= arb_idx;
                        rr_ptr   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                        ser_send <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    ser_send <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    ser_send <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_tx_scheduler.sv
// tb/tb_serializer_tx_scheduler.sv - scoreboard bench for the serializer tx scheduler
module tb_serializer_tx_scheduler;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int FRAME = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   ser_data;
    logic            ser_send;
    logic [0:0]      grant_id;
    logic            busy;

    serializer_tx_scheduler #(
        .N_REQ      (N),
        .DATA_W     (DW),
        .FRAME_CLKS (FRAME)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ser_data  (ser_data),
        .ser_send  (ser_send),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          m_phase = 0;
    int          m_ptr   = 0;
    logic [DW-1:0] m_data = '0;
    int          m_id    = 0;
    logic [15:0] sb[$];
    logic        hs_prev = 1'b0;

    logic          obs_send;
    logic          obs_busy;
    logic [N-1:0]  obs_ready;
    logic [DW-1:0] obs_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the reference model
    task automatic tick();
        int           g;
        logic         any;
        logic [N-1:0] exp_ready;
        logic         hs_now;
        logic [15:0]  ent;
        @(negedge clk);
        g   = 0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req_valid[(m_ptr + k) % N]) begin
                any = 1'b1;
                g   = (m_ptr + k) % N;
            end
        end
        exp_ready = (!rst && en && any && m_phase == 0) ? N'(1 << g) : '0;
        chk("ready", 32'(req_ready), 32'(exp_ready));
        chk("send", 32'(ser_send), 32'(m_phase == 1));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("data_hold", 32'(ser_data), 32'(m_data));
        chk("id_hold", 32'(grant_id), 32'(m_id));
        chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        if (ser_send) begin
            chk("send_after_hs", 32'(hs_prev), 32'd1);
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                ent = sb.pop_front();
                chk("sb_data", 32'(ser_data), 32'(ent[7:0]));
                chk("sb_id", 32'(grant_id), 32'(ent[15:8]));
            end
        end
        obs_send  = ser_send;
        obs_busy  = busy;
        obs_ready = req_ready;
        obs_data  = ser_data;
        hs_now    = |(req_valid & req_ready);
        @(posedge clk);
        cyc++;
        hs_prev = hs_now && !rst;
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_data  = '0;
            m_id    = 0;
            sb.delete();
        end else begin
            if (m_phase == FRAME - 1) m_phase = 0;
            else if (m_phase > 0) m_phase++;
            if (exp_ready != '0) begin
                m_data  = req_data[g*DW +: DW];
                m_id    = g;
                m_ptr   = (g + 1) % N;
                m_phase = 1;
                sb.push_back({8'(g), req_data[g*DW +: DW]});
            end
        end
        #1;
    endtask

    initial begin
        int           n_busy;
        int           n_send;
        int           n_ready;
        logic [DW-1:0] seq[$];
        int            at[$];
        logic [DW-1:0] exp_seq[4];

        rst       = 1'b1;
        en        = 1'b1;
        req_valid = 2'b11;
        req_data  = {8'h22, 8'h11};

        // reset held with all valid high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 32'(obs_ready), 32'd0);
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        tick();
        chk("rst_data", 32'(obs_data), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);

        // single requester 1 with A5
        req_valid = 2'b10;
        req_data  = {8'hA5, 8'h00};
        tick();
        chk("t2_ready", 32'(obs_ready), 32'b10);
        req_valid = 2'b00;
        n_busy = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 0) chk("t2_data", 32'(obs_data), 32'hA5);
            if (obs_busy) n_busy++;
        end
        chk("t2_busy_len", 32'(n_busy), 32'd11);

        // continuous demand from both requesters
        req_valid = 2'b11;
        req_data  = {8'h22, 8'h11};
        for (int i = 0; i < 47; i++) begin
            tick();
            if (obs_send) begin
                seq.push_back(obs_data);
                at.push_back(cyc);
            end
        end
        req_valid = 2'b00;
        for (int i = 0; i < 12; i++) tick();
        exp_seq = '{8'h11, 8'h22, 8'h11, 8'h22};
        chk("t3_nstrobes", 32'(seq.size()), 32'd4);
        for (int i = 0; i < 4 && i < seq.size(); i++) chk("t3_seq", 32'(seq[i]), 32'(exp_seq[i]));
        for (int i = 1; i < at.size(); i++) chk("t3_gap", 32'(at[i] - at[i-1]), 32'(FRAME));

        // enable gating
        en        = 1'b0;
        req_valid = 2'b11;
        n_ready = 0;
        n_send  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs_ready != '0) n_ready++;
            if (obs_send) n_send++;
        end
        chk("t4_noready", 32'(n_ready), 32'd0);
        chk("t4_nosend", 32'(n_send), 32'd0);
        en = 1'b1;
        tick();
        chk("t4_accept", 32'(obs_ready), 32'b01);
        en = 1'b0;
        n_busy = 0;
        n_send = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (obs_busy) n_busy++;
            if (obs_send) n_send++;
        end
        chk("t4_busy_len", 32'(n_busy), 32'd11);
        chk("t4_one_send", 32'(n_send), 32'd1);

        // reset in the middle of a frame
        en        = 1'b1;
        req_valid = 2'b01;
        req_data  = {8'h00, 8'h33};
        tick();
        req_valid = 2'b00;
        tick();
        chk("t5_send", 32'(obs_send), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 2'b10;
        req_data  = {8'h44, 8'h00};
        tick();
        chk("t5_send_drop", 32'(obs_send), 32'd0);
        chk("t5_busy_drop", 32'(obs_busy), 32'd0);
        chk("t5_reaccept", 32'(obs_ready), 32'b10);
        req_valid = 2'b00;
        tick();
        chk("t5_new_data", 32'(obs_data), 32'h44);
        for (int i = 0; i < 12; i++) tick();

        // requester 0 asks during WAIT and withdraws before IDLE
        req_valid = 2'b10;
        req_data  = {8'h55, 8'h66};
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        req_valid = 2'b01;
        n_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (obs_ready[0]) n_ready++;
        end
        req_valid = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_ready[0]) n_ready++;
        end
        chk("t6_no_hs", 32'(n_ready), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
